// File: rtl/sys_bridge.sv
// CPU bridge: decodes DM / timer address ranges, muxes read data, routes strobes, and gathers interrupts.
// Define TIMER1_EN to build the second timer at 0x7F10; otherwise that range is unmapped.

module sys_bridge_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  off,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data_c,
    output logic        irq_c
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    // A CPU write to CTRL/PRESET preempts whatever the FSM would do this cycle.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
        if (wr_en && (off == 2'd0 || off == 2'd1)) begin
            if (off == 2'd0) ctrl_d = wr_data[3:0];
            else             preset_d = wr_data;
            state_d = ST_IDLE;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (ctrl_q[0]) state_d = ST_LOAD;
                ST_LOAD: begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_d = ST_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d = 32'd0;
                        irq_d   = 1'b1;
                        state_d = ST_INT;
                    end
                end
                default: begin
                    if (ctrl_q[2:1] == 2'd1) begin
                        irq_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        case (off)
            2'd0:    rd_data_c = {28'd0, ctrl_q};
            2'd1:    rd_data_c = preset_q;
            2'd2:    rd_data_c = count_q;
            default: rd_data_c = 32'd0;
        endcase
    end

    assign irq_c = irq_q & ctrl_q[3];
endmodule

module sys_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] BrPC,
    input  logic [31:0] BrAddr,
    input  logic [31:0] BrWData,
    input  logic [3:0]  BrWE,
    output logic [31:0] BrRData,
    output logic [7:2]  HWInt,
    output logic [31:0] DMPC,
    output logic [31:0] DMAddr,
    output logic [31:0] DMWData,
    output logic [3:0]  DMWE,
    input  logic [31:0] DMRData,
    input  logic        ExtInt
);
    localparam logic [31:0] DM_HI = 32'h0000_2FFF;
    localparam logic [31:0] T0_LO = 32'h0000_7F00;
    localparam logic [31:0] T0_HI = 32'h0000_7F0B;
    localparam logic [31:0] T1_LO = 32'h0000_7F10;
    localparam logic [31:0] T1_HI = 32'h0000_7F1B;

    logic        dm_hit, t0_hit, t1_hit, wr_full;
    logic [31:0] t0_rdata, t1_rdata;
    logic        t0_irq, t1_irq;
    logic        ext_q, ext_d;

    assign dm_hit  = (BrAddr <= DM_HI);
    assign t0_hit  = (BrAddr >= T0_LO) && (BrAddr <= T0_HI);
    assign t1_hit  = (BrAddr >= T1_LO) && (BrAddr <= T1_HI);
    assign wr_full = (BrWE == 4'hF);

    assign DMPC    = BrPC;
    assign DMAddr  = BrAddr;
    assign DMWData = BrWData;
    assign DMWE    = dm_hit ? BrWE : 4'h0;

    sys_bridge_timer u_t0 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (t0_hit && wr_full),
        .off       (BrAddr[3:2]),
        .wr_data   (BrWData),
        .rd_data_c (t0_rdata),
        .irq_c     (t0_irq)
    );

`ifdef TIMER1_EN
    sys_bridge_timer u_t1 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (t1_hit && wr_full),
        .off       (BrAddr[3:2]),
        .wr_data   (BrWData),
        .rd_data_c (t1_rdata),
        .irq_c     (t1_irq)
    );
`else
    assign t1_rdata = 32'd0;
    assign t1_irq   = 1'b0;
`endif

    always_comb begin
        if (dm_hit)      BrRData = DMRData;
        else if (t0_hit) BrRData = t0_rdata;
        else if (t1_hit) BrRData = t1_rdata;
        else             BrRData = 32'd0;
    end

    assign ext_d = ExtInt;

    always_ff @(posedge clk) begin
        if (reset) ext_q <= 1'b0;
        else       ext_q <= ext_d;
    end

    assign HWInt = {3'b000, ext_q, t1_irq, t0_irq};
endmodule

// File: tb/tb_sys_bridge.sv
// Scoreboard bench for sys_bridge: stimulus queues expectations, a negedge monitor pops and compares.
module tb_sys_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] BrPC, BrAddr, BrWData, BrRData;
    logic [3:0]  BrWE, DMWE;
    logic [7:2]  HWInt;
    logic [31:0] DMPC, DMAddr, DMWData, DMRData;
    logic        ExtInt;

    sys_bridge dut (
        .clk(clk), .reset(reset), .BrPC(BrPC), .BrAddr(BrAddr), .BrWData(BrWData),
        .BrWE(BrWE), .BrRData(BrRData), .HWInt(HWInt), .DMPC(DMPC), .DMAddr(DMAddr),
        .DMWData(DMWData), .DMWE(DMWE), .DMRData(DMRData), .ExtInt(ExtInt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc++;

    // Monitor: sel 0 BrRData, 1 HWInt, 2 DMWE, 3 DMAddr
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = BrRData;
                1:       act = {26'd0, HWInt};
                2:       act = {28'd0, DMWE};
                default: act = DMAddr;
            endcase
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int sel, input logic [31:0] v, input string n);
        sb.push_back('{cyc, sel, v, n});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        BrAddr = a; BrWData = d; BrWE = 4'hF;
        step();
        BrWE = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
        BrAddr = a;
        expect_now(0, v, n);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_cnt [5];
        t1_cnt[0] = 0; t1_cnt[1] = 0; t1_cnt[2] = 3; t1_cnt[3] = 2; t1_cnt[4] = 1;
        reset = 1'b1; BrPC = 32'h0000_3000; BrAddr = 0; BrWData = 0; BrWE = 0;
        DMRData = 0; ExtInt = 0;
        step(); step();
        reset = 1'b0;

        // Reset state
        expect_now(1, 32'h0, "reset_hwint");
        rd(32'h7F00, 32'h0, "reset_ctrl");
        rd(32'h7F04, 32'h0, "reset_preset");
        rd(32'h7F08, 32'h0, "reset_count");
        rd(32'h7F0C, 32'h0, "t0_off3_unmapped");

        // T0 one-shot, PRESET=5: irq 7 cycles after the CTRL write edge, held
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        for (int k = 0; k < 10; k++) begin
            BrAddr = 32'h7F08;
            expect_now(1, (k >= 7) ? 32'h1 : 32'h0, $sformatf("t0_hw_k%0d", k));
            expect_now(0, (k < 2) ? 32'd0 : ((k <= 6) ? 32'(7 - k) : 32'd0), $sformatf("t0_cnt_k%0d", k));
            step();
        end
        expect_now(1, 32'h1, "t0_irq_held");
        rd(32'h7F00, 32'h8, "t0_ctrl_en_cleared");
        rd(32'h7F04, 32'd5, "t0_preset_rb");
        wr(32'h7F00, 32'h0);
        expect_now(1, 32'h0, "t0_irq_cleared_by_write");

        // T1 periodic, PRESET=3: pulse every 5 cycles
        wr(32'h7F14, 32'd3);
        wr(32'h7F10, 32'hB);
        for (int k = 0; k < 17; k++) begin
            BrAddr = 32'h7F18;
`ifdef TIMER1_EN
            expect_now(1, (k > 0 && k % 5 == 0) ? 32'h2 : 32'h0, $sformatf("t1_hw_k%0d", k));
            expect_now(0, t1_cnt[k % 5], $sformatf("t1_cnt_k%0d", k));
`else
            expect_now(1, 32'h0, $sformatf("t1_off_hw_k%0d", k));
            expect_now(0, 32'h0, $sformatf("t1_off_cnt_k%0d", k));
`endif
            step();
        end
`ifdef TIMER1_EN
        rd(32'h7F10, 32'hB, "t1_ctrl_rb");
`else
        rd(32'h7F10, 32'h0, "t1_off_ctrl_rb");
`endif
        wr(32'h7F10, 32'h0);

        // Strobe routing and partial-write filtering
        BrAddr = 32'h3000; BrWData = 32'h1234_5678; BrWE = 4'b0011;
        expect_now(2, 32'h0, "dmwe_outside_dm");
        step();
        BrAddr = 32'h7F00; BrWData = 32'h8; BrWE = 4'b0011;
        expect_now(2, 32'h0, "dmwe_timer_partial");
        step();
        BrWE = 4'h0;
        rd(32'h7F00, 32'h0, "ctrl_partial_ignored");
        BrAddr = 32'h7F00; BrWData = 32'h8; BrWE = 4'hF;
        expect_now(2, 32'h0, "dmwe_timer_full");
        step();
        BrWE = 4'h0;
        rd(32'h7F00, 32'h8, "ctrl_full_written");

        // DM read path and unmapped reads
        DMRData = 32'hDEAD_BEEF;
        BrAddr = 32'h1004; BrWE = 4'b0101;
        expect_now(0, 32'hDEAD_BEEF, "dm_rdata");
        expect_now(2, 32'h5, "dmwe_mirror");
        expect_now(3, 32'h1004, "dmaddr_pass");
        step();
        BrAddr = 32'h2FFF; BrWE = 4'hF;
        expect_now(2, 32'hF, "dmwe_dm_top");
        step();
        BrWE = 4'h0;
        rd(32'h3000, 32'h0, "rd_3000_unmapped");
        rd(32'h8000, 32'h0, "rd_8000_unmapped");

        // ExtInt: one-cycle latency, one-cycle width
        ExtInt = 1'b1;
        expect_now(1, 32'h0, "ext_k0");
        step();
        ExtInt = 1'b0;
        expect_now(1, 32'h4, "ext_k1");
        step();
        expect_now(1, 32'h0, "ext_k2");
        step();

        // PRESET=0 behaves as PRESET=1: irq at offset 3
        wr(32'h7F04, 32'd0);
        wr(32'h7F00, 32'h9);
        for (int k = 0; k < 5; k++) begin
            expect_now(1, (k >= 3) ? 32'h1 : 32'h0, $sformatf("p0_hw_k%0d", k));
            step();
        end

        // Clearing EN mid-count freezes COUNT
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h9);
        step(); step(); step();
        rd(32'h7F08, 32'd9, "freeze_pre");
        wr(32'h7F00, 32'h0);
        rd(32'h7F08, 32'd8, "freeze_a");
        rd(32'h7F08, 32'd8, "freeze_b");

        // Reset mid-count
        wr(32'h7F00, 32'h9);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_now(1, 32'h0, "rst_mid_hw");
        rd(32'h7F08, 32'h0, "rst_mid_count");
        rd(32'h7F00, 32'h0, "rst_mid_ctrl");
        rd(32'h7F04, 32'h0, "rst_mid_preset");

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
